// File: rtl/fc_fixed_pkg.sv
// Fixed-point widths, saturation limits and FSM state encoding for the FC MAC datapath.
// Operands are Q5.11; products and results are Q10.22.
package fc_fixed_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 11;
    localparam int OUT_W  = 32;
    localparam int ACC_W  = 42;
    localparam int LEN_W  = 10;

    localparam logic [OUT_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [OUT_W-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } fc_mac_state_e;

endpackage

// File: rtl/fc_mac_sat.sv
// Combinational clamp of the wide accumulator to a Q10.22 result, with overflow flag.
// Optional ReLU on the clamped value when FC_MAC_RELU_EN is defined.
module fc_mac_sat
    import fc_fixed_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    output logic [OUT_W-1:0] result,
    output logic             ovf
);

    logic [OUT_W-1:0] clamped;
    logic             in_range;

    // The value fits when every bit above the result's sign bit matches that sign bit.
    always_comb begin
        in_range = (acc[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){1'b0}}) ||
                   (acc[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){1'b1}});
        ovf      = !in_range;
        if (in_range) begin
            clamped = acc[OUT_W-1:0];
        end else if (acc[ACC_W-1]) begin
            clamped = SAT_MIN;
        end else begin
            clamped = SAT_MAX;
        end
`ifdef FC_MAC_RELU_EN
        result = clamped[OUT_W-1] ? '0 : clamped;
`else
        result = clamped;
`endif
    end

endmodule

// File: rtl/fc_mac_engine.sv
// Sequential multiply-accumulate for one FC neuron: bias + sum(act*wt), clamped to Q10.22.
// Build option FC_MAC_RELU_EN (handled in fc_mac_sat) zeroes negative results.
module fc_mac_engine
    import fc_fixed_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic [DATA_W-1:0] bias_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] act_in,
    input  logic [DATA_W-1:0] wt_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  acc_out,
    output logic              ovf
);

    fc_mac_state_e state_q, state_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic signed [OUT_W-1:0]  prod_q, prod_d;
    logic                     p1_v_q, p1_v_d;
    logic                     p2_v_q, p2_v_d;
    logic [OUT_W-1:0]         acc_out_q, acc_out_d;
    logic                     ovf_q, ovf_d;

    logic signed [OUT_W-1:0]  act_ext, wt_ext;
    logic [ACC_W-1:0]         bias_ext, prod_ext;
    logic [OUT_W-1:0]         sat_result;
    logic                     sat_ovf;

    fc_mac_sat u_sat (
        .acc    (acc_q),
        .result (sat_result),
        .ovf    (sat_ovf)
    );

    // p2_v marks a cycle in which acc was just written, so DRAIN only
    // samples the clamp once the accumulator has settled for a full cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        prod_d    = prod_q;
        p1_v_d    = 1'b0;
        p2_v_d    = 1'b0;
        acc_out_d = acc_out_q;
        ovf_d     = ovf_q;

        act_ext  = {{(OUT_W-DATA_W){act_in[DATA_W-1]}}, act_in};
        wt_ext   = {{(OUT_W-DATA_W){wt_in[DATA_W-1]}}, wt_in};
        bias_ext = {{(ACC_W-DATA_W){bias_in[DATA_W-1]}}, bias_in};
        prod_ext = {{(ACC_W-OUT_W){prod_q[OUT_W-1]}}, prod_q};

        if (state_q == ACCUM && in_valid) begin
            prod_d = act_ext * wt_ext;
            p1_v_d = 1'b1;
        end
        if (p1_v_q) begin
            acc_d  = acc_q + prod_ext;
            p2_v_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = bias_ext << FRAC_W;
                    cnt_d   = vec_len;
                    p2_v_d  = 1'b1;
                    state_d = (vec_len == '0) ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!p1_v_q && !p2_v_q) begin
                    acc_out_d = sat_result;
                    ovf_d     = sat_ovf;
                    state_d   = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            prod_q    <= '0;
            p1_v_q    <= 1'b0;
            p2_v_q    <= 1'b0;
            acc_out_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            prod_q    <= prod_d;
            p1_v_q    <= p1_v_d;
            p2_v_q    <= p2_v_d;
            acc_out_q <= acc_out_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUTPUT);
    assign acc_out   = acc_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fc_mac_engine.sv
// Scoreboard bench for fc_mac_engine: directed cases plus random vectors against an arithmetic model.
// Honours FC_MAC_RELU_EN in the reference model so it matches either build.
module tb_fc_mac_engine;
    import fc_fixed_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  vec_len;
    logic [DATA_W-1:0] bias_in;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] act_in;
    logic [DATA_W-1:0] wt_in;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  acc_out;
    logic              ovf;

    typedef struct packed {
        logic [31:0] val;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          check_cnt = 0;
    int          pass_cnt  = 0;
    logic [15:0] acts[64];
    logic [15:0] wts[64];

    always #5 clk = ~clk;

    fc_mac_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vec_len   (vec_len),
        .bias_in   (bias_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act_in    (act_in),
        .wt_in     (wt_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .ovf       (ovf)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        check_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Reference: exact integer dot product in Q10.22, then clamp (and ReLU when built in).
    function automatic exp_t model(input int len, input logic [15:0] bias);
        longint sum;
        exp_t   e;
        sum = longint'($signed(bias)) * 2048;
        for (int i = 0; i < len; i++)
            sum += longint'($signed(acts[i])) * longint'($signed(wts[i]));
        if (sum > 64'sd2147483647) begin
            e.val = 32'h7FFF_FFFF;
            e.ovf = 1'b1;
        end else if (sum < -64'sd2147483648) begin
            e.val = 32'h8000_0000;
            e.ovf = 1'b1;
        end else begin
            e.val = sum[31:0];
            e.ovf = 1'b0;
        end
`ifdef FC_MAC_RELU_EN
        if (e.val[31]) e.val = '0;
`endif
        return e;
    endfunction

    // Monitor: every output handshake consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected_result", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("result_acc", acc_out, mon_e.val);
                checkOutput("result_ovf", ovf, mon_e.ovf);
            end
        end
    end

    // gap_mode: 0 = back-to-back, 1 = alternate bubbles, 2 = random bubbles.
    task automatic applyStimulus(input int len, input logic [15:0] bias, input int gap_mode, input bit hold_out);
        exp_t e;
        int   n, i, cyc;
        logic rdy;
        e = model(len, bias);
        sb.push_back(e);
        start   = 1'b1;
        vec_len = len[LEN_W-1:0];
        bias_in = bias;
        @(posedge clk); #1;
        start = 1'b0;
        if (len == 0) begin
            n = 0;
            while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
            checkOutput("lat_bias_only", n, 2);
        end else begin
            i = 0;
            cyc = 0;
            while (i < len && cyc < 500) begin
                case (gap_mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (cyc % 2 == 0);
                    default: in_valid = ($urandom_range(0, 3) != 0);
                endcase
                act_in = in_valid ? acts[i] : 16'($urandom);
                wt_in  = in_valid ? wts[i]  : 16'($urandom);
                rdy = in_ready;
                @(posedge clk); #1;
                if (in_valid && rdy) i++;
                cyc++;
            end
            in_valid = 1'b0;
            checkOutput("beats_accepted", i, len);
            n = 0;
            while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
            checkOutput("lat_last_beat", n, 3);
        end
        if (hold_out) begin
            for (int k = 0; k < 5; k++) begin
                start   = (k == 2);
                vec_len = 10'd2;
                @(posedge clk); #1;
                start = 1'b0;
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_acc", acc_out, e.val);
                checkOutput("hold_ovf", ovf, e.ovf);
                checkOutput("hold_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
            start     = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            checkOutput("release_valid_drop", out_valid, 0);
            checkOutput("release_start_ignored", in_ready, 0);
        end else begin
            n = 0;
            while (!(out_valid && out_ready) && n < 50) begin @(posedge clk); #1; n++; end
            if (n >= 50) checkOutput("handshake_wait", out_valid, 1);
            @(posedge clk); #1;
            checkOutput("valid_drop", out_valid, 0);
        end
    endtask

    task automatic fillConst(input int len, input logic [15:0] a, input logic [15:0] w);
        for (int i = 0; i < len; i++) begin
            acts[i] = a;
            wts[i]  = w;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", pass_cnt, check_cnt);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        vec_len   = '0;
        bias_in   = '0;
        in_valid  = 1'b0;
        act_in    = '0;
        wt_in     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_acc_out", acc_out, 0);
        checkOutput("reset_ovf", ovf, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic dot product");
        fillConst(3, 16'h0800, 16'h1000);
        applyStimulus(3, 16'h0000, 0, 1'b0);

        $display("[TB] bias only");
        applyStimulus(0, 16'hF800, 0, 1'b0);

        $display("[TB] positive saturation");
        fillConst(4, 16'h8000, 16'h8000);
        applyStimulus(4, 16'h0000, 0, 1'b0);

        $display("[TB] negative saturation");
        fillConst(4, 16'h8000, 16'h7FFF);
        applyStimulus(4, 16'h0000, 2, 1'b0);

        $display("[TB] output backpressure");
        fillConst(3, 16'h0800, 16'h1000);
        out_ready = 1'b0;
        applyStimulus(3, 16'h0400, 0, 1'b1);

        $display("[TB] input bubbles");
        fillConst(4, 16'h0800, 16'h0800);
        applyStimulus(4, 16'h0000, 1, 1'b0);

        $display("[TB] reset mid-run");
        start   = 1'b1;
        vec_len = 10'd5;
        bias_in = 16'h0000;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        act_in   = 16'h0800;
        wt_in    = 16'h0800;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        checkOutput("midreset_in_ready", in_ready, 0);
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_acc_out", acc_out, 0);
        checkOutput("midreset_ovf", ovf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_idle", in_ready, 0);
        fillConst(3, 16'h0800, 16'h1000);
        applyStimulus(3, 16'h0000, 0, 1'b0);

        $display("[TB] random vectors");
        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(1, 16);
            for (int i = 0; i < len; i++) begin
                acts[i] = 16'($urandom);
                wts[i]  = 16'($urandom);
            end
            applyStimulus(len, 16'($urandom), r % 3, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
